// File: rtl/user_input_pkg.sv
// Button indices, EV_* event codes and the index-to-event mapping shared by the user-event path.
// Index order doubles as arbitration priority (lowest index wins).
package user_input_pkg;

  localparam int unsigned BTN_NEW_GAME = 0;
  localparam int unsigned BTN_ROTATE   = 1;
  localparam int unsigned BTN_DOWN     = 2;
  localparam int unsigned BTN_LEFT     = 3;
  localparam int unsigned BTN_RIGHT    = 4;
  localparam int unsigned BTN_CNT      = 5;

  // Values mirror the EV_* definitions in defs.vh consumed by the game core.
  localparam logic [2:0] EV_NONE     = 3'd0;
  localparam logic [2:0] EV_LEFT     = 3'd1;
  localparam logic [2:0] EV_RIGHT    = 3'd2;
  localparam logic [2:0] EV_DOWN     = 3'd3;
  localparam logic [2:0] EV_ROTATE   = 3'd4;
  localparam logic [2:0] EV_NEW_GAME = 3'd5;

  function automatic logic [2:0] btn_to_ev(input int unsigned idx);
    case (idx)
      BTN_NEW_GAME: return EV_NEW_GAME;
      BTN_ROTATE:   return EV_ROTATE;
      BTN_DOWN:     return EV_DOWN;
      BTN_LEFT:     return EV_LEFT;
      BTN_RIGHT:    return EV_RIGHT;
      default:      return EV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect one raw push-button into a single-cycle press pulse.
// With USER_EVENT_AUTO_REPEAT_EN defined, REPEAT_EN instances also pulse while the key is held.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
`ifdef USER_EVENT_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter bit          REPEAT_EN       = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_prev_q, level_prev_d;
  logic            synced;
  logic            rise;
  logic            rep_pulse;

  always_comb begin
    sync_d       = {sync_q[0], btn_i};
    synced       = sync_q[1];
    level_d      = level_q;
    cnt_d        = '0;
    level_prev_d = level_q;
    if (synced != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise = level_q & ~level_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
    end
  end

`ifdef USER_EVENT_AUTO_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_DELAY + 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;

  // Counter is 0 in the press-pulse cycle; after a repeat it reloads so the next hit is
  // exactly REPEAT_PERIOD cycles later.
  always_comb begin
    rep_pulse = 1'b0;
    rep_cnt_d = rep_cnt_q;
    if (!REPEAT_EN || !level_q) begin
      rep_cnt_d = '0;
    end else if (rep_cnt_q == RepW'(REPEAT_DELAY)) begin
      rep_pulse = 1'b1;
      rep_cnt_d = RepW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  assign press_o = rise | rep_pulse;

endmodule

// File: rtl/user_event_queue.sv
// Conditions five buttons, arbitrates pending presses and buffers EV_* codes in a show-ahead FIFO.
// Optional auto-repeat for left/right/down is enabled by defining USER_EVENT_AUTO_REPEAT_EN.
module user_event_queue
  import user_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_down_i,
  input  logic       btn_rotate_i,
  input  logic       btn_new_game_i,
  output logic [2:0] user_event_o,
  output logic       user_event_ready_o,
  input  logic       user_event_rd_req_i,
  output logic       overflow_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [BTN_CNT-1:0] btn_raw;
  logic [BTN_CNT-1:0] press;
  logic [BTN_CNT-1:0] pending_q, pending_d;
  logic [BTN_CNT-1:0] grant;
  int unsigned        grant_idx;

  logic [2:0]      mem_q [FIFO_DEPTH];
  logic [2:0]      mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, push_req, push_ok, pop;

  assign btn_raw[BTN_NEW_GAME] = btn_new_game_i;
  assign btn_raw[BTN_ROTATE]   = btn_rotate_i;
  assign btn_raw[BTN_DOWN]     = btn_down_i;
  assign btn_raw[BTN_LEFT]     = btn_left_i;
  assign btn_raw[BTN_RIGHT]    = btn_right_i;

  for (genvar i = 0; i < BTN_CNT; i++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef USER_EVENT_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      ((i == BTN_LEFT) || (i == BTN_RIGHT) || (i == BTN_DOWN))
`endif
    ) u_cond (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_raw[i]),
      .press_o(press[i])
    );
  end

  // Lowest index wins: scan downwards so the last hit is the highest priority.
  always_comb begin
    grant     = '0;
    grant_idx = 0;
    for (int i = BTN_CNT - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = unsigned'(i);
      end
    end
  end

  always_comb begin
    full     = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    push_req = |pending_q;
    pop      = user_event_rd_req_i && (count_q != '0);
    push_ok  = push_req && (!full || pop);

    // A granted bit is always cleared, even when the FIFO drops the event.
    pending_d = (pending_q & ~grant) | press;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = btn_to_ev(grant_idx);
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end

    overflow_d = overflow_q;
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end else if (push_ok && grant[BTN_NEW_GAME]) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign user_event_ready_o = (count_q != '0);
  assign user_event_o       = user_event_ready_o ? mem_q[rd_ptr_q] : 3'd0;
  assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_user_event_queue.sv
// Directed bench for user_event_queue with DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
// Auto-repeat vectors run only when USER_EVENT_AUTO_REPEAT_EN is defined.
module tb_user_event_queue;
  import user_input_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_left, btn_right, btn_down, btn_rotate, btn_new_game;
  logic [2:0] user_event;
  logic       ready;
  logic       rd_req;
  logic       overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  user_event_queue #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .btn_left_i         (btn_left),
    .btn_right_i        (btn_right),
    .btn_down_i         (btn_down),
    .btn_rotate_i       (btn_rotate),
    .btn_new_game_i     (btn_new_game),
    .user_event_o       (user_event),
    .user_event_ready_o (ready),
    .user_event_rd_req_i(rd_req),
    .overflow_o         (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input string tag, input logic [2:0] exp);
    check_eq({tag, "_rdy"}, 32'(ready), 32'd1);
    check_eq({tag, "_ev"}, 32'(user_event), 32'(exp));
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic release_all();
    btn_left     = 1'b0;
    btn_right    = 1'b0;
    btn_down     = 1'b0;
    btn_rotate   = 1'b0;
    btn_new_game = 1'b0;
    repeat (10) tick();
  endtask

  // Counts edges after a press applied just past an edge; ready must rise on edge 8.
  task automatic expect_latency(input string tag, input logic [2:0] exp);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 7) check_eq({tag, "_e7"}, 32'(ready), 32'd0);
    end
    check_eq({tag, "_e8"}, 32'(ready), 32'd1);
    check_eq({tag, "_ev"}, 32'(user_event), 32'(exp));
  endtask

  initial begin
    logic        seen;
    int unsigned n_ev;
    int unsigned ev_edge [8];

    rst          = 1'b1;
    rd_req       = 1'b0;
    btn_left     = 1'b0;
    btn_right    = 1'b0;
    btn_down     = 1'b0;
    btn_rotate   = 1'b0;
    btn_new_game = 1'b0;
    repeat (3) tick();
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_event", 32'(user_event), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean press of left, held 20 cycles
    btn_left = 1'b1;
    expect_latency("press_left", EV_LEFT);
    repeat (12) tick();
    btn_left = 1'b0;
    repeat (12) tick();
    pop_expect("left_only", EV_LEFT);
    check_eq("left_single", 32'(ready), 32'd0);

    // Bounce on rotate, then a clean final rise
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_rotate = ((i / 2) % 2) == 0;
      tick();
      if (ready) seen = 1'b1;
    end
    btn_rotate = 1'b0;
    repeat (2) begin
      tick();
      if (ready) seen = 1'b1;
    end
    check_eq("bounce_quiet", 32'(seen), 32'd0);
    btn_rotate = 1'b1;
    expect_latency("bounce_final", EV_ROTATE);
    release_all();
    pop_expect("bounce_only", EV_ROTATE);
    check_eq("bounce_single", 32'(ready), 32'd0);

    // Simultaneous presses resolve by priority
    btn_left     = 1'b1;
    btn_down     = 1'b1;
    btn_new_game = 1'b1;
    expect_latency("simul_first", EV_NEW_GAME);
    repeat (4) tick();
    release_all();
    pop_expect("simul_ng", EV_NEW_GAME);
    pop_expect("simul_down", EV_DOWN);
    pop_expect("simul_left", EV_LEFT);
    check_eq("simul_empty", 32'(ready), 32'd0);

    // Fill FIFO, drop a fifth event, then push+pop while full
    btn_rotate = 1'b1;
    btn_down   = 1'b1;
    btn_left   = 1'b1;
    btn_right  = 1'b1;
    repeat (12) tick();
    release_all();
    check_eq("full4_no_ovf", 32'(overflow), 32'd0);
    btn_left = 1'b1;
    repeat (12) tick();
    check_eq("full5_ovf", 32'(overflow), 32'd1);
    release_all();
    btn_right = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      rd_req = (e == 7);
    end
    repeat (4) tick();
    release_all();
    pop_expect("full_d0", EV_DOWN);
    pop_expect("full_d1", EV_LEFT);
    pop_expect("full_d2", EV_RIGHT);
    pop_expect("full_d3", EV_RIGHT);
    check_eq("full_drained", 32'(ready), 32'd0);
    btn_new_game = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 7) check_eq("ng_ovf_e7", 32'(overflow), 32'd1);
    end
    check_eq("ng_ovf_clr", 32'(overflow), 32'd0);
    release_all();
    pop_expect("ng_pop", EV_NEW_GAME);

    // rd_req while empty must not underflow
    rd_req = 1'b1;
    repeat (5) tick();
    check_eq("empty_rd_ready", 32'(ready), 32'd0);
    check_eq("empty_rd_event", 32'(user_event), 32'd0);
    rd_req   = 1'b0;
    btn_down = 1'b1;
    expect_latency("after_empty_rd", EV_DOWN);
    release_all();
    pop_expect("after_empty_pop", EV_DOWN);
    check_eq("after_empty_none", 32'(ready), 32'd0);

    // Asynchronous reset mid-stream with overflow set and 3 entries queued
    btn_rotate = 1'b1;
    btn_down   = 1'b1;
    btn_left   = 1'b1;
    btn_right  = 1'b1;
    repeat (12) tick();
    release_all();
    btn_left = 1'b1;
    repeat (12) tick();
    release_all();
    pop_expect("rst_pre_pop", EV_ROTATE);
    check_eq("rst_pre_ovf", 32'(overflow), 32'd1);
    btn_down = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_ready", 32'(ready), 32'd0);
    check_eq("async_rst_ovf", 32'(overflow), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    expect_latency("held_thru_rst", EV_DOWN);
    release_all();
    pop_expect("held_pop", EV_DOWN);
    check_eq("held_single", 32'(ready), 32'd0);

`ifdef USER_EVENT_AUTO_REPEAT_EN
    // Hold right: press at edge 8, repeats at +10, +15, +20, +25
    n_ev      = 0;
    btn_right = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      tick();
      rd_req = 1'b0;
      if (e == 28) btn_right = 1'b0;
      if (ready) begin
        if (n_ev < 8) ev_edge[n_ev] = e;
        n_ev++;
        rd_req = 1'b1;
      end
    end
    rd_req = 1'b0;
    check_eq("rep_count", n_ev, 32'd5);
    check_eq("rep_t0", ev_edge[0], 32'd8);
    check_eq("rep_t1", ev_edge[1], 32'd18);
    check_eq("rep_t2", ev_edge[2], 32'd23);
    check_eq("rep_t3", ev_edge[3], 32'd28);
    check_eq("rep_t4", ev_edge[4], 32'd33);

    n_ev       = 0;
    btn_rotate = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      tick();
      rd_req = 1'b0;
      if (e == 45) btn_rotate = 1'b0;
      if (ready) begin
        n_ev++;
        rd_req = 1'b1;
      end
    end
    rd_req = 1'b0;
    check_eq("rotate_no_repeat", n_ev, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
